// File: rtl/div_bcd_ctrl_if.sv
// Request/result bundle for the fixed-point divide + BCD split block.
interface div_bcd_ctrl_if;
  logic       start;
  logic [9:0] A;
  logic [5:0] B;
  logic       busy;
  logic       done;
  logic       err;
  logic       ovf;
  logic [4:0] D;
  logic [3:0] l1;
  logic [3:0] l2;

  modport master (output start, A, B,
                  input  busy, done, err, ovf, D, l1, l2);
  modport slave  (input  start, A, B,
                  output busy, done, err, ovf, D, l1, l2);
endinterface

// File: rtl/div_bcd_ctrl.sv
// Divides a 8.2 quarter-fraction dividend by a 6-bit divisor and splits the
// quotient (scaled by 100) into a 5-bit integer and two decimal digits.
// One shared restoring-division step serves all three phases: /B, /100, /10.
module div_bcd_ctrl (
  input  logic          clk,
  input  logic          rst_n,
  div_bcd_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, DIV, CONV, DIGIT} state_t;

  state_t      state_q;
  logic [14:0] sh_q;    // dividend shifted out MSB-first, quotient shifted in
  logic [7:0]  rem_q;   // partial remainder, always below the current divisor
  logic [5:0]  b_q;
  logic [7:0]  int_q;   // Q/100 held while the last digit split runs
  logic [3:0]  cnt_q;
  logic        busy_q, done_q, err_q, ovf_q;
  logic [4:0]  d_q;
  logic [3:0]  l1_q, l2_q;

  logic [14:0] n_in;
  logic [6:0]  dvsr;
  logic [8:0]  trial, diff;
  logic        ge, last;
  logic [7:0]  rem_d;
  logic [14:0] sh_d;

  // Scaled dividend and one restoring-division step for the active phase
  always_comb begin
    n_in  = 15'(bus.A[9:2]) * 15'd100 + 15'(bus.A[1:0]) * 15'd25;
    dvsr  = 7'd0;
    last  = 1'b0;
    case (state_q)
      DIV:     begin dvsr = {1'b0, b_q}; last = (cnt_q == 4'd14); end
      CONV:    begin dvsr = 7'd100;      last = (cnt_q == 4'd14); end
      DIGIT:   begin dvsr = 7'd10;       last = (cnt_q == 4'd6);  end
      default: begin dvsr = 7'd0;        last = 1'b0;             end
    endcase
    trial = {rem_q, sh_q[14]};
    diff  = trial - {2'b00, dvsr};
    ge    = (trial >= {2'b00, dvsr});
    rem_d = ge ? diff[7:0] : trial[7:0];
    sh_d  = {sh_q[13:0], ge};
  end

  // Control FSM with registered outputs; results only move on the final edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sh_q    <= '0;
      rem_q   <= '0;
      b_q     <= '0;
      int_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
      d_q     <= '0;
      l1_q    <= '0;
      l2_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (bus.start) begin
            if (bus.B == 6'd0) begin
              // Divide-by-zero resolves on the accepting edge itself
              err_q  <= 1'b1;
              ovf_q  <= 1'b0;
              d_q    <= '0;
              l1_q   <= '0;
              l2_q   <= '0;
              done_q <= 1'b1;
            end else begin
              sh_q    <= n_in;
              b_q     <= bus.B;
              rem_q   <= '0;
              busy_q  <= 1'b1;
              state_q <= DIV;
            end
          end
        end
        DIV: begin
          rem_q <= rem_d;
          sh_q  <= sh_d;
          cnt_q <= cnt_q + 4'd1;
          if (last) begin
            // Remainder of N/B is dropped; Q stays in sh_q for the /100 pass
            rem_q   <= '0;
            cnt_q   <= '0;
            state_q <= CONV;
          end
        end
        CONV: begin
          rem_q <= rem_d;
          sh_q  <= sh_d;
          cnt_q <= cnt_q + 4'd1;
          if (last) begin
            // Q/100 <= 255 fits 8 bits; park Q%100 at the top for the /10 pass
            int_q   <= sh_d[7:0];
            sh_q    <= {rem_d[6:0], 8'd0};
            rem_q   <= '0;
            cnt_q   <= '0;
            state_q <= DIGIT;
          end
        end
        DIGIT: begin
          rem_q <= rem_d;
          sh_q  <= sh_d;
          cnt_q <= cnt_q + 4'd1;
          if (last) begin
            d_q     <= int_q[4:0];
            ovf_q   <= |int_q[7:5];
            err_q   <= 1'b0;
            l1_q    <= sh_d[3:0];
            l2_q    <= rem_d[3:0];
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.err  = err_q;
  assign bus.ovf  = ovf_q;
  assign bus.D    = d_q;
  assign bus.l1   = l1_q;
  assign bus.l2   = l2_q;
endmodule

// File: tb/tb_div_bcd_ctrl.sv
// Scoreboard bench: stimulus pushes hand-computed results with the edge they
// are due on; a negedge monitor pops and compares on every done pulse.
module tb_div_bcd_ctrl;
  typedef struct {
    logic       err;
    logic       ovf;
    logic [4:0] d;
    logic [3:0] l1;
    logic [3:0] l2;
    int         edge_n;
  } exp_t;

  logic clk, rst_n;
  div_bcd_ctrl_if bus ();
  div_bcd_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  exp_t sbq[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   ecnt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) ecnt <= ecnt + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, ecnt);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      if (sbq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 expected no result (edge %0d)", ecnt);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("latency_edge", ecnt, e.edge_n);
        chk("err", int'(bus.err), int'(e.err));
        chk("ovf", int'(bus.ovf), int'(e.ovf));
        chk("D",   int'(bus.D),   int'(e.d));
        chk("l1",  int'(bus.l1),  int'(e.l1));
        chk("l2",  int'(bus.l2),  int'(e.l2));
      end
    end
  end

  // Present a request; the accept edge is the next posedge. Returns at the
  // negedge after the accept, with A/B scrambled to prove they were latched.
  task automatic issue(input bit sync, input logic [9:0] a, input logic [5:0] b,
                       input logic err, input logic ovf, input logic [4:0] d,
                       input logic [3:0] l1, input logic [3:0] l2);
    exp_t e;
    if (sync) @(negedge clk);
    bus.A = a;
    bus.B = b;
    bus.start = 1'b1;
    e.err = err; e.ovf = ovf; e.d = d; e.l1 = l1; e.l2 = l2;
    e.edge_n = ecnt + 1 + ((b == 6'd0) ? 0 : 37);
    sbq.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    bus.A = 10'($urandom);
    bus.B = 6'($urandom);
    chk("busy_after_accept", int'(bus.busy), (b == 6'd0) ? 0 : 1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0) begin
      chk("result_timeout", sbq.size(), 0);
      sbq.delete();
    end
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, int'(bus.busy), 0);
    chk({tag, "_done"}, int'(bus.done), 0);
    chk({tag, "_err"},  int'(bus.err),  0);
    chk({tag, "_ovf"},  int'(bus.ovf),  0);
    chk({tag, "_D"},    int'(bus.D),    0);
    chk({tag, "_l1"},   int'(bus.l1),   0);
    chk({tag, "_l2"},   int'(bus.l2),   0);
  endtask

  initial begin
    int n;
    bit got;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.A = '0;
    bus.B = '0;
    #3;
    chk_all_zero("reset");
    @(negedge clk);
    #2 rst_n = 1'b1;

    // 25.25 / 5 = 5.05
    issue(1, 10'b0001100101, 6'd5, 0, 0, 5'd5, 4'd0, 4'd5);
    wait_idle();
    // 3.50 / 3 -> 116 truncated
    issue(1, 10'b0000001110, 6'd3, 0, 0, 5'd1, 4'd1, 4'd6);
    wait_idle();
    // 255.75 / 1 -> 25575, integer 255 overflows
    issue(1, 10'b1111111111, 6'd1, 0, 1, 5'd31, 4'd7, 4'd5);
    wait_idle();
    // divide by zero resolves on the accept edge, busy stays low
    issue(1, 10'h155, 6'd0, 1, 0, 5'd0, 4'd0, 4'd0);
    wait_idle();
    chk("b0_busy_idle", int'(bus.busy), 0);
    // 10.75 / 7 -> 1075/7 = 153
    issue(1, 10'b0000101011, 6'd7, 0, 0, 5'd1, 4'd5, 4'd3);
    wait_idle();

    // 100.00 / 63 -> 10000/63 = 158; start mid-op ignored, outputs held
    issue(1, 10'd400, 6'd63, 0, 0, 5'd1, 4'd5, 4'd8);
    repeat (9) @(negedge clk);
    chk("hold_D", int'(bus.D), 1);
    chk("hold_l1", int'(bus.l1), 5);
    chk("hold_l2", int'(bus.l2), 3);
    chk("busy_mid", int'(bus.busy), 1);
    bus.A = 10'd1;
    bus.B = 6'd1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    got = 0;
    n = 0;
    while (!got && n < 60) begin
      @(negedge clk);
      n++;
      if (bus.done) got = 1;
    end
    chk("done_seen", int'(got), 1);
    // back-to-back: start during the done cycle, 0.25 / 1 -> 25
    if (got) issue(0, 10'd1, 6'd1, 0, 0, 5'd0, 4'd2, 4'd5);
    wait_idle();

    // reset mid-operation: no done, everything cleared at once
    issue(1, 10'b1111111111, 6'd2, 0, 0, 5'd0, 4'd0, 4'd0);
    repeat (18) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    void'(sbq.pop_back());
    chk_all_zero("midrst");
    #1 rst_n = 1'b1;
    repeat (45) @(negedge clk);
    chk("midrst_no_done_D", int'(bus.D), 0);
    // 0.00 / 63 after reset recovery
    issue(1, 10'd0, 6'd63, 0, 0, 5'd0, 4'd0, 4'd0);
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/div_bcd_ctrl.md
DIV_BCD_CTRL -- requirements
Module: div_bcd_ctrl

Interface
REQ-001 The block SHALL have no parameters; all widths below are fixed.
REQ-002 clk  input  1  single clock, all state changes on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request pulse, sampled only while idle.
REQ-005 A  input  10  dividend; A[9:2] is the integer part, A[1:0] the quarter fraction (00=.00, 01=.25, 10=.50, 11=.75).
REQ-006 B  input  6  unsigned divisor.
REQ-007 busy  output  1  high from the accepting edge until the result edge.
REQ-008 done  output  1  one-cycle result-valid pulse.
REQ-009 err  output  1  divide-by-zero flag for the last request.
REQ-010 ovf  output  1  integer result exceeded 31 for the last request.
REQ-011 D  output  5  integer part of the quotient, binary.
REQ-012 l1  output  4  first decimal digit of the quotient, binary 0-9.
REQ-013 l2  output  4  second decimal digit of the quotient, binary 0-9.

Function
REQ-014 States SHALL be IDLE, DIV, CONV and DIGIT; the state register SHALL be sequential, not a combinational recompute.
REQ-015 In IDLE with start=1 at edge 0 (accept):
- latch N = A[9:2]*100 + frac, with frac = 0/25/50/75, as 15 bits (max 25575);
- latch B;
- set busy=1 and go to DIV.
REQ-016 If B==0 at edge 0:
- go directly to IDLE with no division;
- at edge 0, D=0, l1=0, l2=0, ovf=0, err=1, done=1 for one cycle, busy=0.
REQ-017 DIV SHALL perform a 15-iteration restoring division of N by B (one quotient bit per edge, edges 1-15, 7-bit partial remainder), producing truncated quotient Q (15 bits), then go to CONV.
- The remainder of N/B is discarded.
REQ-018 CONV SHALL perform a 15-iteration restoring division of Q by 100 (edges 16-30), producing I = Q/100 and R = Q%100, then go to DIGIT.
REQ-019 DIGIT SHALL perform a 7-iteration restoring division of R by 10 (edges 31-37), producing R/10 and R%10.
REQ-020 At edge 37 the block SHALL:
- register D = I[4:0], l1 = R/10, l2 = R%10, ovf = (I>31), err=0;
- pulse done=1 for exactly one cycle;
- drop busy and return to IDLE.
- Latency is fixed at 37 cycles from the accepting edge.
REQ-021 D, l1, l2, ovf and err SHALL hold their values until the next result edge; they SHALL NOT change during DIV, CONV or DIGIT.
REQ-022 start SHALL be ignored while busy=1; A and B MAY change after the accepting edge without affecting the result.
REQ-023 start=1 in the cycle where done=1 SHALL be accepted at the next edge, giving back-to-back operation with one idle cycle between requests.
REQ-024 An iteration counter SHALL sequence each phase; counter wrap SHALL NOT occur outside its phase.

Reset
REQ-025 rst_n=0 SHALL immediately, independent of clk:
- force state IDLE;
- clear busy, done, err, ovf, D, l1, l2 and all internal registers to 0.
REQ-026 A reset asserted mid-operation SHALL abort the operation with no done pulse.
- After release the block SHALL accept a new start normally.

Verification
REQ-027 A=10'b0001100101 (25.25), B=5, start -> 37 cycles later done=1, D=5, l1=0, l2=5, ovf=0, err=0.
REQ-028 A=10'b0000001110 (3.50), B=3 -> D=1, l1=1, l2=6 (Q=116, truncated).
REQ-029 A=10'b1111111111 (255.75), B=1 -> Q=25575, D=31, l1=7, l2=5, ovf=1.
REQ-030 A=any, B=0 -> done at edge 0 (same edge as accept), err=1, D=l1=l2=0, busy never high after that edge.
REQ-031 Second start pulsed at cycle 10 of a busy operation -> ignored, exactly one done.
- Then start in the done cycle -> second result arrives 37 cycles later.
REQ-032 rst_n pulsed low at cycle 20 of an operation -> all outputs 0 immediately, no done.
- Then A=0, B=63 -> D=0, l1=0, l2=0.
